// File: rtl/conv_top_system.sv
// Streaming K x K convolution MAC engine: one multiply-accumulate per accepted pair, one result per pixel/channel.
// Optional macro CONV_STRIDE_EN enables the per-run stride select; without it the stride is fixed at 1.
module conv_top_system #(
   parameter int IO_DATA_WIDTH      = 16,
   parameter int ACCUMULATION_WIDTH = 16,
   parameter int FEATURE_MAP_WIDTH  = 128,
   parameter int FEATURE_MAP_HEIGHT = 128,
   parameter int INPUT_NB_CHANNELS  = 2,
   parameter int OUTPUT_NB_CHANNELS = 16,
   parameter int KERNEL_SIZE        = 3
) (
   input  logic                                  clk,
   input  logic                                  arst_n_in,
   input  logic [1:0]                            conv_stride_mode,
   input  logic [IO_DATA_WIDTH-1:0]              a_input,
   input  logic [IO_DATA_WIDTH-1:0]              b_input,
   input  logic                                  a_valid,
   output logic                                  a_ready,
   output logic [IO_DATA_WIDTH-1:0]              out,
   output logic                                  output_valid,
   output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
   output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
   output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
   input  logic                                  start,
   output logic                                  running
);
   localparam int XW   = $clog2(FEATURE_MAP_WIDTH);
   localparam int YW   = $clog2(FEATURE_MAP_HEIGHT);
   localparam int CHW  = $clog2(OUTPUT_NB_CHANNELS);
   localparam int CINW = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
   localparam int KW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int PW   = 2 * IO_DATA_WIDTH;

   localparam logic [CINW-1:0] CIN_LAST = CINW'(INPUT_NB_CHANNELS - 1);
   localparam logic [KW-1:0]   K_LAST   = KW'(KERNEL_SIZE - 1);
   localparam logic [CHW-1:0]  CH_LAST  = CHW'(OUTPUT_NB_CHANNELS - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t state, state_nxt;

   logic [CINW-1:0]               cin_cnt;
   logic [KW-1:0]                 kx_cnt, ky_cnt;
   logic [CHW-1:0]                ch_cnt;
   logic [XW-1:0]                 x_cnt;
   logic [YW-1:0]                 y_cnt;
   logic [ACCUMULATION_WIDTH-1:0] acc, acc_nxt, prod;
   logic signed [PW-1:0]          a_ext, b_ext;
   logic [IO_DATA_WIDTH-1:0]      res;
   logic [XW+2:0]                 x_step;
   logic [YW+2:0]                 y_step;
   logic                          hs, first_term, term_last, x_wrap, y_wrap, run_last;

`ifdef CONV_STRIDE_EN
   logic [2:0] stride;
   always_ff @(posedge clk) begin
      if (arst_n_in)
         stride <= 3'd1;
      else if (state == IDLE && start) begin
         case (conv_stride_mode)
            2'd0:    stride <= 3'd1;
            2'd1:    stride <= 3'd2;
            default: stride <= 3'd4;
         endcase
      end
   end
`else
   localparam logic [2:0] stride = 3'd1;
   logic unused_stride_mode;
   assign unused_stride_mode = ^conv_stride_mode;
`endif

   assign hs         = a_valid && (state == RUN);
   assign a_ready    = (state == RUN);
   assign running    = (state == RUN);
   assign x_step     = (XW+3)'(x_cnt) + (XW+3)'(stride);
   assign y_step     = (YW+3)'(y_cnt) + (YW+3)'(stride);
   assign x_wrap     = x_step >= (XW+3)'(FEATURE_MAP_WIDTH);
   assign y_wrap     = y_step >= (YW+3)'(FEATURE_MAP_HEIGHT);
   assign first_term = (cin_cnt == '0) && (kx_cnt == '0) && (ky_cnt == '0);
   assign term_last  = (cin_cnt == CIN_LAST) && (kx_cnt == K_LAST) && (ky_cnt == K_LAST);
   assign run_last   = term_last && (ch_cnt == CH_LAST) && x_wrap && y_wrap;

   // Full-width signed product, then keep only the low accumulator bits (wrapping arithmetic).
   assign a_ext   = PW'($signed(a_input));
   assign b_ext   = PW'($signed(b_input));
   assign prod    = ACCUMULATION_WIDTH'(a_ext * b_ext);
   assign acc_nxt = (first_term ? '0 : acc) + prod;
   assign res     = IO_DATA_WIDTH'($signed(acc_nxt));

   always_ff @(posedge clk) begin
      if (arst_n_in)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (hs && run_last) state_nxt = FLUSH;
         FLUSH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (arst_n_in) begin
         cin_cnt      <= '0;
         kx_cnt       <= '0;
         ky_cnt       <= '0;
         ch_cnt       <= '0;
         x_cnt        <= '0;
         y_cnt        <= '0;
         acc          <= '0;
         out          <= '0;
         output_x     <= '0;
         output_y     <= '0;
         output_ch    <= '0;
         output_valid <= 1'b0;
      end else begin
         output_valid <= 1'b0;
         if (state == IDLE && start) begin
            cin_cnt <= '0;
            kx_cnt  <= '0;
            ky_cnt  <= '0;
            ch_cnt  <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            acc     <= '0;
         end else if (hs) begin
            acc <= acc_nxt;
            if (term_last) begin
               out          <= res;
               output_x     <= x_cnt;
               output_y     <= y_cnt;
               output_ch    <= ch_cnt;
               output_valid <= 1'b1;
            end
            // Innermost cin, then kx, ky, ch, x, y; each carries into the next when it wraps.
            if (cin_cnt != CIN_LAST)
               cin_cnt <= cin_cnt + CINW'(1);
            else begin
               cin_cnt <= '0;
               if (kx_cnt != K_LAST)
                  kx_cnt <= kx_cnt + KW'(1);
               else begin
                  kx_cnt <= '0;
                  if (ky_cnt != K_LAST)
                     ky_cnt <= ky_cnt + KW'(1);
                  else begin
                     ky_cnt <= '0;
                     if (ch_cnt != CH_LAST)
                        ch_cnt <= ch_cnt + CHW'(1);
                     else begin
                        ch_cnt <= '0;
                        if (!x_wrap)
                           x_cnt <= x_step[XW-1:0];
                        else begin
                           x_cnt <= '0;
                           y_cnt <= y_wrap ? '0 : y_step[YW-1:0];
                        end
                     end
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_conv_top_system.sv
// Self-checking bench for conv_top_system on a 4x4, Cin=2, Cout=2, K=3 build.
module tb_conv_top_system;
   localparam int W = 4, H = 4, CIN = 2, COUT = 2, K = 3;
   localparam int TERMS = K * K * CIN;
   localparam int NT = W * H * COUT * TERMS;

   logic        clk = 1'b0;
   logic        arst_n_in = 1'b1;
   logic [1:0]  conv_stride_mode = 2'd0;
   logic [15:0] a_input = '0, b_input = '0;
   logic        a_valid = 1'b0, start = 1'b0;
   logic        a_ready, output_valid, running;
   logic [15:0] out;
   logic [1:0]  output_x, output_y;
   logic        output_ch;

   always #5 clk = ~clk;

   conv_top_system #(
      .IO_DATA_WIDTH(16), .ACCUMULATION_WIDTH(16),
      .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
      .INPUT_NB_CHANNELS(CIN), .OUTPUT_NB_CHANNELS(COUT), .KERNEL_SIZE(K)
   ) dut (
      .clk(clk), .arst_n_in(arst_n_in), .conv_stride_mode(conv_stride_mode),
      .a_input(a_input), .b_input(b_input), .a_valid(a_valid), .a_ready(a_ready),
      .out(out), .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
      .output_ch(output_ch), .start(start), .running(running)
   );

   typedef struct { logic [1:0] mode; logic [15:0] a; logic [15:0] b; logic [15:0] exp; int gap; } vec_t;
   typedef struct { int x; int y; int ch; logic [15:0] v; } res_t;

   int checks = 0, errors = 0;
   logic [15:0] ta [NT];
   logic [15:0] tb_w [NT];
   res_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_stride(input logic [1:0] m);
`ifdef CONV_STRIDE_EN
      return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
`else
      return 1;
`endif
   endfunction

   // Reference: walk the output pixels in raster order and sum K*K*Cin products as plain integers.
   task automatic build_model(input int s);
      int k, sum;
      exp_q.delete();
      k = 0;
      for (int y = 0; y < H; y += s)
         for (int x = 0; x < W; x += s)
            for (int c = 0; c < COUT; c++) begin
               sum = 0;
               for (int t = 0; t < TERMS; t++) begin
                  sum += $signed(ta[k]) * $signed(tb_w[k]);
                  k++;
               end
               exp_q.push_back('{x, y, c, 16'(sum)});
            end
   endtask

   task automatic do_run(input logic [1:0] mode, input int gap, input bit rnd,
                         input logic [15:0] ca, input logic [15:0] cb,
                         input bit use_cexp, input logic [15:0] cexp);
      int s, nout, n, idx, out_i, seen, cycles;
      bit av, hs, pending;
      s    = model_stride(mode);
      nout = ((W + s - 1) / s) * ((H + s - 1) / s) * COUT;
      n    = nout * TERMS;
      for (int i = 0; i < n; i++) begin
         ta[i]   = rnd ? 16'($urandom) : ca;
         tb_w[i] = rnd ? 16'($urandom) : cb;
      end
      build_model(s);
      @(negedge clk);
      start = 1'b1;
      conv_stride_mode = mode;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("running_rise", running, 1);
      idx = 0; out_i = 0; seen = 0; cycles = 0; pending = 0;
      while (out_i < nout && cycles < 20 * n) begin
         if (output_valid === 1'b1) seen++;
         if (pending) begin
            chk("out_valid", output_valid, 1);
            chk("out_val", out, exp_q[out_i].v);
            chk("out_x", output_x, exp_q[out_i].x);
            chk("out_y", output_y, exp_q[out_i].y);
            chk("out_ch", output_ch, exp_q[out_i].ch);
            if (use_cexp) chk("out_const", out, cexp);
            out_i++;
            if (out_i == nout) begin
               chk("running_fall", running, 0);
               chk("ready_fall", a_ready, 0);
            end
         end else if (output_valid !== 1'b0) begin
            chk("spurious_valid", output_valid, 0);
         end
         av = (idx < n) && ($urandom_range(99) >= gap);
         if (idx < n) begin
            chk("ready_run", a_ready, 1);
            // Stride mode and start toggles during the run must have no effect.
            conv_stride_mode = 2'($urandom);
            start = 1'($urandom);
         end else
            start = 1'b0;
         a_valid = av;
         a_input = av ? ta[idx] : 16'($urandom);
         b_input = av ? tb_w[idx] : 16'($urandom);
         hs = av && a_ready;
         @(posedge clk);
         if (hs) idx++;
         pending = hs && (idx % TERMS == 0);
         @(negedge clk);
         cycles++;
      end
      a_valid = 1'b0;
      start = 1'b0;
      if (cycles >= 20 * n) chk("timeout_outputs", out_i, nout);
      chk("out_count", seen, nout);
      chk("idle_valid", output_valid, 0);
      chk("idle_ready", a_ready, 0);
      chk("idle_running", running, 0);
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{2'd0, 16'h0001, 16'h0001, 16'd18,   0};
      vecs[1] = '{2'd1, 16'h0002, 16'hFFFD, 16'hFF94, 0};
      vecs[2] = '{2'd0, 16'h0100, 16'h0100, 16'h0000, 0};
      vecs[3] = '{2'd0, 16'h7FFF, 16'h0002, 16'hFFDC, 50};

      // Reset held with a_valid high.
      arst_n_in = 1'b1;
      a_valid = 1'b1;
      a_input = 16'h1234;
      b_input = 16'h5678;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_ready", a_ready, 0);
         chk("rst_running", running, 0);
         chk("rst_valid", output_valid, 0);
         chk("rst_out", out, 0);
         chk("rst_x", output_x, 0);
         chk("rst_y", output_y, 0);
         chk("rst_ch", output_ch, 0);
      end
      arst_n_in = 1'b0;
      a_valid = 1'b0;

      foreach (vecs[i])
         do_run(vecs[i].mode, vecs[i].gap, 1'b0, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp);

      // Abort a run part-way with reset, then confirm the next run starts clean.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a_input = 16'h0005;
      b_input = 16'h0007;
      a_valid = 1'b1;
      repeat (25) @(negedge clk);
      a_valid = 1'b0;
      arst_n_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("midrst_valid", output_valid, 0);
         chk("midrst_ready", a_ready, 0);
         chk("midrst_running", running, 0);
      end
      arst_n_in = 1'b0;
      a_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("post_rst_valid", output_valid, 0);
         chk("post_rst_ready", a_ready, 0);
      end
      a_valid = 1'b0;

      do_run(2'd0, 50, 1'b1, 16'h0, 16'h0, 1'b0, 16'h0);
      do_run(2'($urandom_range(3)), 50, 1'b1, 16'h0, 16'h0, 1'b0, 16'h0);
      do_run(2'd2, 0, 1'b1, 16'h0, 16'h0, 1'b0, 16'h0);
      do_run(2'd1, 30, 1'b1, 16'h0, 16'h0, 1'b0, 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
